// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input and received-byte outputs of the 8N1 UART receiver
//   rs232_rx  : serial line into the receiver, idles high
//   rx_data   : last correctly framed byte
//   rx_done   : one-cycle pulse, rx_data updated in the same cycle
//   frame_err : one-cycle pulse when the stop bit samples low
//   rx_busy   : high while a frame is being received
interface uart_rx_if;
    logic       rs232_rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;
    modport master (input rs232_rx, output rx_data, rx_done, frame_err, rx_busy);
    modport slave  (output rs232_rx, input rx_data, rx_done, frame_err, rx_busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, mid-bit sampling with a clk-domain baud counter
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : uart_rx_if.master (rs232_rx in; rx_data, rx_done, frame_err, rx_busy out)
module uart_rx #(
    parameter int BAUD_DIV = 868,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst,
    uart_rx_if.master  bus
);
    localparam int CW = $clog2(BAUD_DIV);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, idx_n;
    logic [7:0]    shift, shift_n, data, data_n;
    logic          done, done_n, ferr, ferr_n, busy, busy_n;
    logic          rx_m, rx_s, rx_d;

    // Synchronizer resets to the idle level so releasing reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {rx_m, rx_s, rx_d} <= 3'b111;
            state <= IDLE;
            cnt <= '0;
            bit_idx <= '0;
            shift <= '0;
            data <= '0;
            done <= 1'b0;
            ferr <= 1'b0;
            busy <= 1'b0;
        end else begin
            {rx_m, rx_s, rx_d} <= {bus.rs232_rx, rx_m, rx_s};
            state <= state_n;
            cnt <= cnt_n;
            bit_idx <= idx_n;
            shift <= shift_n;
            data <= data_n;
            done <= done_n;
            ferr <= ferr_n;
            busy <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt + CW'(1);
        idx_n = bit_idx;
        shift_n = shift;
        data_n = data;
        done_n = 1'b0;
        ferr_n = 1'b0;
        busy_n = busy;
        case (state)
            IDLE: begin
                cnt_n = '0;
                busy_n = rx_d && !rx_s;
                state_n = (rx_d && !rx_s) ? START : IDLE;
            end
            // A start bit that is high again at its midpoint is a glitch.
            START: if (cnt == CW'(HALF_DIV - 1)) begin
                cnt_n = '0;
                idx_n = '0;
                state_n = rx_s ? IDLE : DATA;
                busy_n = !rx_s;
            end
            DATA: if (cnt == CW'(BAUD_DIV - 1)) begin
                cnt_n = '0;
                shift_n[bit_idx] = rx_s;
                idx_n = bit_idx + 3'd1;
                state_n = (bit_idx == 3'd7) ? STOP : DATA;
            end
            // Leaving at mid-stop leaves half a bit to re-arm for a back-to-back start.
            STOP: if (cnt == CW'(BAUD_DIV - 1)) begin
                cnt_n = '0;
                state_n = IDLE;
                busy_n = 1'b0;
                data_n = rx_s ? shift : data;
                done_n = rx_s;
                ferr_n = !rx_s;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.rx_data = data;
    assign bus.rx_done = done;
    assign bus.frame_err = ferr;
    assign bus.rx_busy = busy;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: the receive end of the serial link whose transmit end drives rs232_tx.
- Oversamples the asynchronous rs232_rx line in the system clock domain and samples each bit at its midpoint.
- Presents each received byte with a one-cycle valid pulse, and flags stop-bit framing errors.
- Sits between the board RX pin and the command or loopback logic. It pairs with uart_tx on the same clk, with an identical baud divider.

Parameters:
- BAUD_DIV, 868, clk cycles per bit (115200 baud at 100 MHz); must be >= 8.
- HALF_DIV, BAUD_DIV/2, cycles from the detected start edge to the start-bit midpoint.

Ports:
- clk  input  1  system clock, 100 MHz nominal.
- rst  input  1  asynchronous, active-high reset.
- rs232_rx  input  1  serial line, asynchronous to clk, idles high.
- rx_data  output  8  last correctly framed byte, LSB first on the wire; holds between frames.
- rx_done  output  1  one-cycle pulse; rx_data is valid and updated in the same cycle.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- rx_busy  output  1  high from start-edge detection until the return to IDLE.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. Reset values:
  - rx_data = 8'h00; rx_done, frame_err and rx_busy = 0.
  - State = IDLE; counters = 0.
  - Synchronizer flops = 1, so no false edge is seen on release.
- Input conditioning: a 2-FF synchronizer produces rx_s; a third flop produces rx_d. A start edge is rx_d==1 && rx_s==0.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - On a start edge: go to START, clear the baud counter, set rx_busy.
  - Otherwise stay in IDLE with rx_busy = 0.
- START:
  - The baud counter counts to HALF_DIV-1, then samples rx_s.
  - rx_s==0: go to DATA, clear the counter and clear bit_idx.
  - rx_s==1: false start (glitch). Return to IDLE with no pulse on any output.
- DATA:
  - Every BAUD_DIV cycles (counter wraps at BAUD_DIV-1), sample rx_s into shift[bit_idx], LSB first.
  - After bit_idx==7 is sampled, go to STOP.
- STOP:
  - After BAUD_DIV cycles, sample rx_s.
  - rx_s==1: rx_data <= shift and rx_done = 1 for exactly one cycle.
  - rx_s==0: frame_err = 1 for one cycle and rx_data is unchanged.
  - In both cases go to IDLE in the same cycle. rx_busy drops at the mid-stop-bit sample.
- Back-to-back frames: because the receiver returns to IDLE at mid-stop, a start edge arriving immediately after a full stop bit is caught. Zero idle gap between frames must be supported.
- Start-edge detection during START, DATA or STOP is ignored. Edges are re-armed only in IDLE.
- Break (line held low):
  - Produces a frame_err.
  - No new frame starts until rs232_rx returns high and then falls again, because edge detection needs rx_d==1.
- Latency: the rx_done rising edge occurs HALF_DIV + 9*BAUD_DIV + 3 (±1) cycles after the rs232_rx falling edge of the start bit.
- rx_done and frame_err are never asserted in the same cycle. Neither is asserted while rst is high.
- Reset asserted mid-frame:
  - All outputs return to their reset values immediately.
  - After release the block waits in IDLE for a fresh falling edge. A partial frame never produces rx_done.
- Arithmetic: the baud counter is clog2(BAUD_DIV) bits wide; bit_idx is 3 bits. No other arithmetic.

Test Plan:
- Bench conditions: BAUD_DIV=16, 10 ns clk. rst held high for 100 ns, then released. The bench model drives rs232_rx at 16 cycles/bit.
- Single byte: send 8'h55 -> exactly one rx_done pulse; rx_data==8'h55; frame_err stays 0; rx_busy high for about 152 cycles.
- Back-to-back with zero idle gap: send 8'hA3, 8'h00, 8'hFF, 8'h81 -> four rx_done pulses; rx_data matches each byte in order; no frame_err.
- Framing error: send 8'h3C with the stop bit driven low, then idle high -> one frame_err pulse, no rx_done, rx_data keeps its previous value. A following 8'h12 is received correctly.
- Glitch: a 4-cycle low pulse on an idle line -> rx_busy rises then returns to 0 after about 8 cycles; no rx_done, no frame_err, and the next 8'hC5 frame is received correctly.
- Reset mid-frame: assert rst during bit 3 of 8'hF0 -> outputs go to reset values asynchronously (rx_data==0) and no pulse occurs for that frame. A subsequent 8'h0F is received and rx_done fires once.
- Latency check: for 8'h01, measure from the start-bit falling edge to rx_done -> 8 + 144 + 3 = 155 cycles (±1).
